if_2_half: RTL and testbench

- Second half of the instruction-fetch stage. Sits between the PC/translation half (which supplies the physical fetch address, PC, pc_valid and the fetch exception code) and the decode stage.
- Issues one request at a time on the SRAM-like instruction bus (req/addr_ok/data_ok).
- Buffers the returned instruction until decode accepts it.
- Drops responses that belong to fetches killed by a branch or exception flush.

---
 rtl/if_2_half_pkg.sv | 18 +
 rtl/if_cancel_ctr.sv | 37 +++
 rtl/if_2_half.sv | 120 ++++++++++++
 tb/tb_if_2_half.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_2_half_pkg.sv
// Shared definitions for the second half of the instruction-fetch stage:
// datapath widths, fetch exception codes and the fetch FSM state encoding.
package if_2_half_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int EXC_WIDTH  = 5;

  // Exception codes carried alongside a fetched instruction
  localparam logic [EXC_WIDTH-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_WIDTH-1:0] EXC_ADEL = 5'd4;

  // Fetch FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/if_cancel_ctr.sv
// Remembers that a killed fetch still owes one response on the instruction
// bus, so that response can be swallowed when it finally arrives.
module if_cancel_ctr
  import if_2_half_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic data_ok_i,
  output logic cancel_o
);

  logic cancel_q;
  logic cancel_d;

  // Set when a flush orphans an accepted request; the next data beat clears it
  always_comb begin
    cancel_d = cancel_q;
    if (set_i) begin
      cancel_d = 1'b1;
    end else if (cancel_q && data_ok_i) begin
      cancel_d = 1'b0;
    end
  end

  // Flag register; reset never sets it because the bus is reset alongside us
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cancel_q <= 1'b0;
    end else begin
      cancel_q <= cancel_d;
    end
  end

  assign cancel_o = cancel_q;

endmodule

// File: rtl/if_2_half.sv
// Second half of instruction fetch: issues one SRAM-like bus read per PC,
// holds the returned instruction for decode and drops flushed responses.
module if_2_half
  import if_2_half_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int EXC_W  = EXC_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] paddr_in,
  input  logic              pc_valid,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              flush,
  output logic              inst_req,
  output logic [DATA_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_exc
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              cancel;
  logic              cancelSet;
  logic              accept;

  // A new PC may enter when nothing is pending, or when decode drains the held one
  assign f_ready = ((state_q == ST_IDLE) && !cancel && !flush) ||
                   ((state_q == ST_HOLD) && id_ready && !flush);
  assign accept  = f_valid && f_ready;

  // A flush orphans a bus transaction once the address has been taken but data has not returned
  assign cancelSet = flush && (((state_q == ST_REQ) && inst_addr_ok) ||
                               ((state_q == ST_WAIT) && !inst_data_ok));

  if_cancel_ctr u_cancel (
    .clk       (clk),
    .reset     (reset),
    .set_i     (cancelSet),
    .data_ok_i (inst_data_ok),
    .cancel_o  (cancel)
  );

  // Next-state and datapath capture; flush overrides everything and returns to IDLE
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_REQ:  if (inst_addr_ok) state_d = ST_WAIT;
        ST_WAIT: begin
          if (inst_data_ok) begin
            state_d = ST_HOLD;
            inst_d  = inst_rdata;
          end
        end
        ST_HOLD: if (id_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        pc_d   = pc_in;
        addr_d = paddr_in;
        exc_d  = exc_in;
        if (pc_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
          inst_d  = '0;
        end
      end
    end
  end

  // State and held-fetch registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
    end
  end

  assign inst_req  = (state_q == ST_REQ);
  assign inst_addr = addr_q;
  assign id_valid  = (state_q == ST_HOLD);
  assign id_pc     = pc_q;
  assign id_inst   = inst_q;
  assign id_exc    = exc_q;

  // Read data with nothing outstanding means the bus broke protocol
  assert property (@(posedge clk) disable iff (reset)
                   !((state_q == ST_IDLE) && !cancel && inst_data_ok));

endmodule

// File: tb/tb_if_2_half.sv
// Self-checking bench for if_2_half: directed fetch scenarios followed by a
// randomized run, all compared against a transaction-level fetch model.
module tb_if_2_half;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] pc_in;
  logic [31:0] paddr_in;
  logic        pc_valid;
  logic [4:0]  exc_in;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_exc;

  if_2_half dut (
    .clk          (clk),
    .reset        (reset),
    .f_valid      (f_valid),
    .f_ready      (f_ready),
    .pc_in        (pc_in),
    .paddr_in     (paddr_in),
    .pc_valid     (pc_valid),
    .exc_in       (exc_in),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_exc       (id_exc)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Fetch model: which fetch is waiting for what, plus any orphaned response
  bit          holding, wantAddr, wantData, orphan;
  logic [31:0] curPc, curAddr, heldPc, heldInst;
  logic [4:0]  curExc, heldExc;

  // Bus slave model: one outstanding read with a countdown to its data beat
  bit          busOut;
  int          busCnt;
  logic [31:0] busAddr;
  int          aokMode;
  int          dataDelay;
  logic [31:0] memOverride [bit [31:0]];

  bit          sampFready;
  int          sawDead;

  logic        fvR, pvR, flR, idrR;
  logic [31:0] pcR;

  // Instruction memory contents: a few pinned words, the rest derived from the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (memOverride.exists(a)) return memOverride[a];
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // Forget every in-flight fetch and bus transaction
  task automatic clearModel();
    holding  = 1'b0;
    wantAddr = 1'b0;
    wantData = 1'b0;
    orphan   = 1'b0;
    busOut   = 1'b0;
    busCnt   = 0;
  endtask

  // Drive one cycle of upstream/decode inputs, answer as the bus, check, then advance the model
  task automatic applyStimulus(input bit fv, input logic [31:0] pc, input logic [31:0] pa,
                               input bit pv, input logic [4:0] exc, input bit fl, input bit idr);
    bit expFready, expAccept, aok, dok;
    bit nHold, nWA, nWD, nOr;
    f_valid  = fv;
    pc_in    = pc;
    paddr_in = pa;
    pc_valid = pv;
    exc_in   = exc;
    flush    = fl;
    id_ready = idr;
    expFready = !fl && ((!holding && !wantAddr && !wantData && !orphan) || (holding && idr));
    expAccept = fv && expFready;
    aok = 1'b0;
    if (wantAddr) aok = (aokMode < 0) ? ($urandom_range(0, 1) == 1) : (aokMode != 0);
    dok = busOut && (busCnt == 0);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? memWord(busAddr) : $urandom;
    #1;
    sampFready = f_ready;
    if (id_valid && id_inst == 32'hDEADBEEF) sawDead++;
    checkOutput("f_ready", {31'd0, f_ready}, {31'd0, expFready});
    checkOutput("inst_req", {31'd0, inst_req}, {31'd0, wantAddr});
    if (wantAddr) checkOutput("inst_addr", inst_addr, curAddr);
    checkOutput("id_valid", {31'd0, id_valid}, {31'd0, holding});
    if (holding) begin
      checkOutput("id_pc", id_pc, heldPc);
      checkOutput("id_inst", id_inst, heldInst);
      checkOutput("id_exc", {27'd0, id_exc}, {27'd0, heldExc});
    end
    if (dok) busOut = 1'b0;
    else if (busOut) busCnt--;
    if (wantAddr && aok) begin
      busOut  = 1'b1;
      busAddr = curAddr;
      busCnt  = (dataDelay < 0) ? $urandom_range(0, 2) : dataDelay;
    end
    nHold = holding;
    nWA   = wantAddr;
    nWD   = wantData;
    nOr   = orphan;
    if (orphan && dok) nOr = 1'b0;
    if (fl) begin
      if ((wantAddr && aok) || (wantData && !dok)) nOr = 1'b1;
      nHold = 1'b0;
      nWA   = 1'b0;
      nWD   = 1'b0;
    end else begin
      if (wantAddr && aok) begin
        nWA = 1'b0;
        nWD = 1'b1;
      end
      if (wantData && dok) begin
        nWD      = 1'b0;
        nHold    = 1'b1;
        heldPc   = curPc;
        heldInst = inst_rdata;
        heldExc  = curExc;
      end
      if (holding && idr) nHold = 1'b0;
      if (expAccept) begin
        curPc   = pc;
        curAddr = pa;
        curExc  = exc;
        if (pv) begin
          nWA = 1'b1;
        end else begin
          nHold    = 1'b1;
          heldPc   = pc;
          heldInst = 32'd0;
          heldExc  = exc;
        end
      end
    end
    holding  = nHold;
    wantAddr = nWA;
    wantData = nWD;
    orphan   = nOr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Quiet cycles with decode always ready, to let a fetch drain
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
  endtask

  // Directed scenarios, then randomized traffic
  initial begin
    reset = 1'b1;
    f_valid = 1'b0; pc_in = '0; paddr_in = '0; pc_valid = 1'b0; exc_in = '0;
    flush = 1'b0; id_ready = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    sawDead = 0;
    clearModel();
    memOverride[32'h1FC00000] = 32'h3C1D0000;
    memOverride[32'h1FC00100] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset f_ready", {31'd0, f_ready}, 32'd1);
    checkOutput("reset inst_req", {31'd0, inst_req}, 32'd0);
    checkOutput("reset inst_addr", inst_addr, 32'd0);
    checkOutput("reset id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("reset id_pc", id_pc, 32'd0);
    checkOutput("reset id_inst", id_inst, 32'd0);
    checkOutput("reset id_exc", {27'd0, id_exc}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    aokMode = 1; dataDelay = 0;
    applyStimulus(1'b1, 32'hBFC00000, 32'h1FC00000, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("basic req", {31'd0, inst_req}, 32'd1);
    checkOutput("basic addr", inst_addr, 32'h1FC00000);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("basic no early valid", {31'd0, id_valid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("basic id_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("basic id_pc", id_pc, 32'hBFC00000);
    checkOutput("basic id_inst", id_inst, 32'h3C1D0000);
    checkOutput("basic id_exc", {27'd0, id_exc}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      checkOutput("stall f_ready", {31'd0, sampFready}, 32'd0);
      checkOutput("stall id_inst", id_inst, 32'h3C1D0000);
      checkOutput("stall id_pc", id_pc, 32'hBFC00000);
    end
    applyStimulus(1'b1, 32'hBFC00004, 32'h1FC00004, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("release accept", {31'd0, sampFready}, 32'd1);
    checkOutput("release req", {31'd0, inst_req}, 32'd1);
    checkOutput("release addr", inst_addr, 32'h1FC00004);
    idleCycles(4);

    applyStimulus(1'b1, 32'hBFC00002, 32'h1FC00002, 1'b0, 5'd4, 1'b0, 1'b0);
    checkOutput("fault no req", {31'd0, inst_req}, 32'd0);
    checkOutput("fault id_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("fault id_inst", id_inst, 32'd0);
    checkOutput("fault id_exc", {27'd0, id_exc}, 32'd4);
    idleCycles(2);

    dataDelay = 2;
    applyStimulus(1'b1, 32'hBFC00100, 32'h1FC00100, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hBFC00380, 32'h1FC00380, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("wait flush blocked 1", {31'd0, sampFready}, 32'd0);
    applyStimulus(1'b1, 32'hBFC00380, 32'h1FC00380, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("wait flush blocked 2", {31'd0, sampFready}, 32'd0);
    dataDelay = 0;
    applyStimulus(1'b1, 32'hBFC00380, 32'h1FC00380, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("wait flush reopen", {31'd0, sampFready}, 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("refetch id_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("refetch id_pc", id_pc, 32'hBFC00380);
    checkOutput("refetch id_inst", id_inst, memWord(32'h1FC00380));
    checkOutput("no killed data", sawDead, 32'd0);
    idleCycles(2);

    dataDelay = 1;
    applyStimulus(1'b1, 32'hBFC00400, 32'h1FC00400, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hBFC00404, 32'h1FC00404, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("req flush cancel", {31'd0, sampFready}, 32'd0);
    applyStimulus(1'b1, 32'hBFC00404, 32'h1FC00404, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("req flush drop beat", {31'd0, sampFready}, 32'd0);
    applyStimulus(1'b1, 32'hBFC00404, 32'h1FC00404, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("req flush reopen", {31'd0, sampFready}, 32'd1);
    idleCycles(5);

    dataDelay = 0;
    applyStimulus(1'b1, 32'hBFC00500, 32'h1FC00500, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    checkOutput("data flush no cancel", {31'd0, sampFready}, 32'd1);
    idleCycles(2);

    dataDelay = 3;
    applyStimulus(1'b1, 32'hBFC00200, 32'h1FC00200, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    f_valid = 1'b0; flush = 1'b0; id_ready = 1'b1; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1;
    checkOutput("wait before reset", {31'd0, f_ready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset inst_req", {31'd0, inst_req}, 32'd0);
    checkOutput("async reset id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("async reset f_ready", {31'd0, f_ready}, 32'd1);
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    idleCycles(2);

    aokMode = -1; dataDelay = -1;
    for (int i = 0; i < 3000; i++) begin
      fvR  = ($urandom_range(0, 9) < 7);
      pvR  = ($urandom_range(0, 9) != 0);
      flR  = ($urandom_range(0, 9) == 0);
      idrR = ($urandom_range(0, 9) < 7);
      pcR  = $urandom & 32'hFFFF_FFFC;
      applyStimulus(fvR, pcR, pcR & 32'h1FFF_FFFF, pvR, pvR ? 5'd0 : 5'd4, flR, idrR);
    end
    idleCycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
